// File: rtl/pulse_burst_scheduler.sv
// pulse_burst_scheduler
//   Shares one pulse-train output between two requesters (A, B). A granted
//   request emits count_x pulses, each high for high_time cycles and low for
//   low_time cycles. Round-robin arbitration, registered ack/done strobes and
//   an abort input that still ends the burst with a done strobe.
//
// Ports
//   clock             system clock, posedge
//   reset             synchronous active-low reset
//   req_a / req_b     level requests, held until the matching ack
//   count_a / count_b pulse count per burst, latched at grant (0 = ignored)
//   high_time         high cycles per pulse, latched at grant (0 acts as 1)
//   low_time          low cycles per pulse, latched at grant (0 acts as 1)
//   abort             ends a burst in HIGH/LOW on the next edge
//   signal            registered pulse-train output
//   ack_a / ack_b     one-cycle grant strobes
//   done_a / done_b   one-cycle burst-complete strobes
//   busy              high while a burst is in HIGH, LOW or DONE
//   owner             current or last grantee (0 = A, 1 = B)
//
// state | meaning
// IDLE  | no burst; arbitrate eligible requests
// HIGH  | signal high, timer counting the high phase
// LOW   | signal low, timer counting the low phase
// DONE  | done strobe for the owner, then back to IDLE

module pulse_burst_scheduler #(
  parameter int CNT_W  = 8,
  parameter int TIME_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_a,
  input  logic [CNT_W-1:0]  count_a,
  input  logic              req_b,
  input  logic [CNT_W-1:0]  count_b,
  input  logic [TIME_W-1:0] high_time,
  input  logic [TIME_W-1:0] low_time,
  input  logic              abort,
  output logic              signal,
  output logic              ack_a,
  output logic              ack_b,
  output logic              done_a,
  output logic              done_b,
  output logic              busy,
  output logic              owner
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW, DONE} state_t;

  localparam logic [TIME_W-1:0] T_ONE = TIME_W'(1);
  localparam logic [CNT_W-1:0]  C_ONE = CNT_W'(1);

  state_t            state, state_n;
  logic [CNT_W-1:0]  rem, rem_n;
  logic [TIME_W-1:0] tmr, tmr_n;
  logic [TIME_W-1:0] hi_m1, hi_m1_n;
  logic [TIME_W-1:0] lo_m1, lo_m1_n;
  logic              rr, rr_n;
  logic              signal_n, ack_a_n, ack_b_n, done_a_n, done_b_n;
  logic              busy_n, owner_n;
  logic              elig_a, elig_b, win_b;

  assign elig_a = req_a && (count_a != '0);
  assign elig_b = req_b && (count_b != '0);
  // B wins when it is the only eligible side, or both are and the pointer says B.
  assign win_b  = elig_b && (!elig_a || rr);

  always_comb begin
    state_n  = state;
    rem_n    = rem;
    tmr_n    = tmr;
    hi_m1_n  = hi_m1;
    lo_m1_n  = lo_m1;
    rr_n     = rr;
    signal_n = signal;
    ack_a_n  = 1'b0;
    ack_b_n  = 1'b0;
    done_a_n = 1'b0;
    done_b_n = 1'b0;
    busy_n   = busy;
    owner_n  = owner;
    case (state)
      IDLE: begin
        if (elig_a || elig_b) begin
          owner_n  = win_b;
          ack_a_n  = !win_b;
          ack_b_n  = win_b;
          rem_n    = win_b ? count_b : count_a;
          // Timers hold "cycles - 1"; a zero width behaves like one cycle.
          hi_m1_n  = (high_time == '0) ? '0 : high_time - T_ONE;
          lo_m1_n  = (low_time == '0) ? '0 : low_time - T_ONE;
          tmr_n    = hi_m1_n;
          signal_n = 1'b1;
          busy_n   = 1'b1;
          state_n  = HIGH;
          if (elig_a && elig_b)
            rr_n = !win_b;
        end
      end
      HIGH: begin
        if (abort) begin
          signal_n = 1'b0;
          done_a_n = !owner;
          done_b_n = owner;
          state_n  = DONE;
        end else if (tmr == '0) begin
          signal_n = 1'b0;
          tmr_n    = lo_m1;
          state_n  = LOW;
        end else begin
          tmr_n = tmr - T_ONE;
        end
      end
      LOW: begin
        if (abort) begin
          signal_n = 1'b0;
          done_a_n = !owner;
          done_b_n = owner;
          state_n  = DONE;
        end else if (tmr == '0) begin
          if (rem > C_ONE) begin
            rem_n    = rem - C_ONE;
            signal_n = 1'b1;
            tmr_n    = hi_m1;
            state_n  = HIGH;
          end else begin
            rem_n    = '0;
            done_a_n = !owner;
            done_b_n = owner;
            state_n  = DONE;
          end
        end else begin
          tmr_n = tmr - T_ONE;
        end
      end
      DONE: begin
        signal_n = 1'b0;
        busy_n   = 1'b0;
        state_n  = IDLE;
      end
      default: begin
        signal_n = 1'b0;
        busy_n   = 1'b0;
        state_n  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state  <= IDLE;
      rem    <= '0;
      tmr    <= '0;
      hi_m1  <= '0;
      lo_m1  <= '0;
      rr     <= 1'b0;
      signal <= 1'b0;
      ack_a  <= 1'b0;
      ack_b  <= 1'b0;
      done_a <= 1'b0;
      done_b <= 1'b0;
      busy   <= 1'b0;
      owner  <= 1'b0;
    end else begin
      state  <= state_n;
      rem    <= rem_n;
      tmr    <= tmr_n;
      hi_m1  <= hi_m1_n;
      lo_m1  <= lo_m1_n;
      rr     <= rr_n;
      signal <= signal_n;
      ack_a  <= ack_a_n;
      ack_b  <= ack_b_n;
      done_a <= done_a_n;
      done_b <= done_b_n;
      busy   <= busy_n;
      owner  <= owner_n;
    end
  end

endmodule

// File: tb/tb_pulse_burst_scheduler.sv
module tb_pulse_burst_scheduler;

  logic       clock;
  logic       reset;
  logic       req_a, req_b, abort;
  logic [7:0] count_a, count_b, high_time, low_time;
  logic       signal, ack_a, ack_b, done_a, done_b, busy, owner;

  int n_checks = 0;
  int n_pass   = 0;

  pulse_burst_scheduler #(.CNT_W(8), .TIME_W(8)) dut (
    .clock(clock), .reset(reset),
    .req_a(req_a), .count_a(count_a),
    .req_b(req_b), .count_b(count_b),
    .high_time(high_time), .low_time(low_time),
    .abort(abort), .signal(signal),
    .ack_a(ack_a), .ack_b(ack_b),
    .done_a(done_a), .done_b(done_b),
    .busy(busy), .owner(owner)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  // Advance past the next posedge; outputs are sampled and inputs driven here.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Sample signal, then advance; first sample is the current cycle.
  task automatic run_sig(input int n, output logic [31:0] v);
    v = '0;
    for (int i = 0; i < n; i++) begin
      v = {v[30:0], signal};
      tick();
    end
  endtask

  logic [31:0] v, v2;
  logic [15:0] aa, ab, da, db;
  logic        any;

  initial begin
    reset = 1'b0; req_a = 0; req_b = 0; abort = 0;
    count_a = 0; count_b = 0; high_time = 0; low_time = 0;
    tick(); tick();
    check_val("rst_outputs", {signal, ack_a, ack_b, done_a, done_b, busy, owner}, 0);
    reset = 1'b1;

    // single burst: N=3 H=3 L=2
    req_a = 1; count_a = 3; high_time = 3; low_time = 2;
    tick();
    check_val("t1_ack_a", ack_a, 1);
    check_val("t1_busy", busy, 1);
    req_a = 0;
    v = {31'b0, signal};
    tick();
    check_val("t1_ack_one_cycle", ack_a, 0);
    run_sig(14, v2);
    v = {v[16:0], v2[13:0]};
    check_val("t1_pattern", v[14:0], 15'b111001110011100);
    check_val("t1_done_a", {done_a, done_b, signal, busy}, 4'b1001);
    tick();
    check_val("t1_idle", {done_a, busy, owner}, 3'b000);

    // arbitration: both held, N=1 H=1 L=1
    req_a = 1; req_b = 1; count_a = 1; count_b = 1; high_time = 1; low_time = 1;
    aa = 0; ab = 0; da = 0; db = 0;
    for (int k = 0; k < 16; k++) begin
      tick();
      aa = {aa[14:0], ack_a}; ab = {ab[14:0], ack_b};
      da = {da[14:0], done_a}; db = {db[14:0], done_b};
    end
    req_a = 0; req_b = 0;
    check_val("arb_ack_a", aa, 16'h8080);
    check_val("arb_ack_b", ab, 16'h0808);
    check_val("arb_done_a", da, 16'h2020);
    check_val("arb_done_b", db, 16'h0202);
    check_val("arb_no_double_ack", aa & ab, 0);
    tick(); tick();

    // zero count on B is ignored
    req_b = 1; count_b = 0;
    any = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      any = any | ack_b | done_b | busy;
    end
    check_val("zero_cnt_ignored", any, 0);
    req_b = 0;

    // zero widths act as one cycle
    req_a = 1; count_a = 2; high_time = 0; low_time = 0;
    tick();
    req_a = 0;
    run_sig(4, v);
    check_val("zero_hl_pattern", v[3:0], 4'b1010);
    check_val("zero_hl_done", done_a, 1);
    tick();
    check_val("zero_hl_idle", busy, 0);

    // abort in LOW, sampled at the 6th edge after grant
    req_a = 1; count_a = 5; high_time = 4; low_time = 4;
    tick();
    check_val("ab_ack", ack_a, 1);
    req_a = 0;
    run_sig(5, v);
    check_val("ab_pre", v[4:0], 5'b11110);
    abort = 1;
    tick();
    abort = 0;
    check_val("ab_done", {signal, done_a, busy}, 3'b011);
    tick();
    check_val("ab_idle", {done_a, busy}, 2'b00);
    any = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      any = any | signal | done_a | ack_a;
    end
    check_val("ab_quiet", any, 0);

    // reset during HIGH; req_a stays pending
    req_a = 1; count_a = 3; high_time = 3; low_time = 2;
    tick(); tick();
    check_val("rm_in_high", signal, 1);
    reset = 0;
    tick();
    check_val("rm_cleared", {signal, busy, done_a, ack_a}, 4'b0000);
    reset = 1;
    tick();
    check_val("rm_regrant", {ack_a, signal}, 2'b11);
    req_a = 0;
    run_sig(15, v);
    check_val("rm_pattern", v[14:0], 15'b111001110011100);
    check_val("rm_done", done_a, 1);
    tick();

    // config change mid-burst
    req_a = 1; count_a = 2; high_time = 3; low_time = 2;
    tick();
    req_a = 0;
    run_sig(2, v);
    high_time = 7;
    run_sig(8, v2);
    v = {v[21:0], v2[7:0]};
    check_val("cfg_latched", v[9:0], 10'b1110011100);
    check_val("cfg_done", done_a, 1);
    tick();
    req_b = 1; count_b = 1; low_time = 1;
    tick();
    req_b = 0;
    check_val("cfg_ack_b", {ack_b, owner}, 2'b11);
    run_sig(8, v);
    check_val("cfg_new_h", v[7:0], 8'b11111110);
    check_val("cfg_done_b", {done_b, done_a}, 2'b10);
    tick();
    check_val("cfg_idle", {busy, owner}, 2'b01);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
